// File: rtl/wave_gen_pkg.sv
// Shared definitions for the wave_gen waveform generator:
// waveform mode encodings, default widths and the step synchronizer states.
package wave_gen_pkg;

  localparam int DEFAULT_PHASE_W  = 8;
  localparam int DEFAULT_SAMPLE_W = 12;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'b00,
    WAVE_SAW    = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_DC     = 2'b11
  } wave_mode_t;

  // The synchronizer must see a genuine low before it may report a rising edge.
  typedef enum logic [1:0] {
    SYNC_FILL0,
    SYNC_FILL1,
    SYNC_WAIT_LOW,
    SYNC_ARMED
  } sync_state_t;

endpackage

// File: rtl/wave_gen_step_sync.sv
// Two-flop synchronizer plus history flop for the divided clock, producing a
// one-clk rising-edge pulse; edges are suppressed until a real low has been seen.
module step_sync
  import wave_gen_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic step_in,
  output logic step
);

  logic        sync1;
  logic        sync2;
  logic        hist;
  sync_state_t state;
  sync_state_t state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
      state <= SYNC_FILL0;
    end else begin
      sync1 <= step_in;
      sync2 <= sync1;
      hist  <= sync2;
      state <= state_next;
    end
  end

  // The two fill states let the chain flush its reset zeros, so a step_in held
  // high across reset release cannot masquerade as a rising edge.
  always_comb begin
    state_next = state;
    step       = 1'b0;
    case (state)
      SYNC_FILL0:    state_next = SYNC_FILL1;
      SYNC_FILL1:    state_next = SYNC_WAIT_LOW;
      SYNC_WAIT_LOW: if (!sync2) state_next = SYNC_ARMED;
      SYNC_ARMED:    step = sync2 & ~hist;
      default:       state_next = SYNC_FILL0;
    endcase
  end

endmodule

// File: rtl/wave_gen.sv
// Phase-accumulator waveform generator: advances one phase step per divided-clock
// edge and maps the phase to square, sawtooth, triangle or DC samples.
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int PHASE_W  = DEFAULT_PHASE_W,
  parameter int SAMPLE_W = DEFAULT_SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step_in,
  input  logic                enable,
  input  logic [1:0]          wave_sel,
  input  logic [1:0]          amp_shift,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                cycle_start
);

  logic                step;
  logic [PHASE_W-1:0]  phase;
  logic [PHASE_W-1:0]  phase_next;
  wave_mode_t          mode;
  wave_mode_t          mode_next;
  logic [PHASE_W-2:0]  tri_src;
  logic [SAMPLE_W-1:0] saw_raw;
  logic [SAMPLE_W-1:0] tri_raw;
  logic [SAMPLE_W-1:0] raw;
  logic [SAMPLE_W-1:0] shifted;

  step_sync u_step_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_in (step_in),
    .step    (step)
  );

  // A new waveform request is only honoured on the wrap, keeping periods whole.
  always_comb begin
    phase_next = phase + PHASE_W'(1);
    mode_next  = (phase_next == '0) ? wave_mode_t'(wave_sel) : mode;
  end

  always_comb begin
    tri_src = phase_next[PHASE_W-1] ? ~phase_next[PHASE_W-2:0] : phase_next[PHASE_W-2:0];
    saw_raw = '0;
    tri_raw = '0;
    for (int i = 0; i < SAMPLE_W; i++) begin
      saw_raw[SAMPLE_W-1-i] = phase_next[PHASE_W-1-(i % PHASE_W)];
      tri_raw[SAMPLE_W-1-i] = tri_src[PHASE_W-2-(i % (PHASE_W-1))];
    end
    case (mode_next)
      WAVE_SQUARE: raw = {SAMPLE_W{phase_next[PHASE_W-1]}};
      WAVE_SAW:    raw = saw_raw;
      WAVE_TRI:    raw = tri_raw;
      default:     raw = {1'b1, {(SAMPLE_W-1){1'b0}}};
    endcase
    shifted = raw >> amp_shift;
  end

  // Disable dominates a coincident step; while idle the mode tracks wave_sel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase        <= '0;
      mode         <= WAVE_SQUARE;
      sample       <= '0;
      sample_valid <= 1'b0;
      cycle_start  <= 1'b0;
    end else if (!enable) begin
      phase        <= '0;
      mode         <= wave_mode_t'(wave_sel);
      sample       <= '0;
      sample_valid <= 1'b0;
      cycle_start  <= 1'b0;
    end else if (step) begin
      phase        <= phase_next;
      mode         <= mode_next;
      sample       <= shifted;
      sample_valid <= 1'b1;
      cycle_start  <= (phase_next == '0);
    end else begin
      sample_valid <= 1'b0;
      cycle_start  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wave_gen.sv
// Directed bench for wave_gen: a reference model queues each expected sample
// when a step is driven and a monitor pops and compares on sample_valid.
module tb_wave_gen;
  import wave_gen_pkg::*;

  typedef struct {
    logic [11:0] smp;
    logic        cs;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        step_in;
  logic        enable;
  logic [1:0]  wave_sel;
  logic [1:0]  amp_shift;
  logic [11:0] sample;
  logic        sample_valid;
  logic        cycle_start;

  exp_t        sb[$];
  logic [7:0]  m_phase;
  logic [1:0]  m_mode;
  int          errors = 0;
  int          checks = 0;

  wave_gen #(.PHASE_W(8), .SAMPLE_W(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .step_in      (step_in),
    .enable       (enable),
    .wave_sel     (wave_sel),
    .amp_shift    (amp_shift),
    .sample       (sample),
    .sample_valid (sample_valid),
    .cycle_start  (cycle_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] model_sample(input logic [7:0] p, input logic [1:0] m,
                                               input logic [1:0] sh);
    logic [11:0] r;
    logic [6:0]  t;
    case (m)
      2'b00: r = p[7] ? 12'hFFF : 12'h000;
      2'b01: r = {p, p[7:4]};
      2'b10: begin
        t = p[7] ? ~p[6:0] : p[6:0];
        r = {t, t[6:2]};
      end
      default: r = 12'h800;
    endcase
    return r >> sh;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_disable();
    m_phase = 8'd0;
    m_mode  = wave_sel;
  endtask

  task automatic push_step();
    logic [7:0] np;
    logic [1:0] nm;
    exp_t       e;
    np    = m_phase + 8'd1;
    nm    = (np == 8'd0) ? wave_sel : m_mode;
    e.smp = model_sample(np, nm, amp_shift);
    e.cs  = (np == 8'd0);
    sb.push_back(e);
    m_phase = np;
    m_mode  = nm;
  endtask

  // One divided-clock period of 20 clk, called at a falling clk edge.
  task automatic apply_stimulus();
    if (enable) push_step();
    step_in = 1'b1;
    repeat (10) @(negedge clk);
    step_in = 1'b0;
    repeat (10) @(negedge clk);
    check_output("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sample_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("unexpected_valid", 32'(sample_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check_output("sb_sample", 32'(sample), 32'(e.smp));
        check_output("sb_cycle_start", 32'(cycle_start), 32'(e.cs));
      end
    end else if (cycle_start !== 1'b0) begin
      check_output("cs_without_valid", 32'(cycle_start), 32'd0);
    end
  end

  initial begin
    rst_n     = 1'b0;
    step_in   = 1'b0;
    enable    = 1'b0;
    wave_sel  = WAVE_SAW;
    amp_shift = 2'd0;
    m_phase   = 8'd0;
    m_mode    = WAVE_SQUARE;
    #12;
    check_output("reset_sample", 32'(sample), 32'd0);
    check_output("reset_valid", 32'(sample_valid), 32'd0);
    check_output("reset_cycle_start", 32'(cycle_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    model_disable();
    enable = 1'b1;

    $display("[TB] sawtooth period, switching request to square at phase 50");
    for (int i = 1; i <= 256; i++) begin
      apply_stimulus();
      if (i == 1)   check_output("saw_step1", 32'(sample), 32'h010);
      if (i == 2)   check_output("saw_step2", 32'(sample), 32'h020);
      if (i == 50)  wave_sel = WAVE_SQUARE;
      if (i == 255) check_output("saw_step255", 32'(sample), 32'hFFF);
    end
    check_output("wrap_sample", 32'(sample), 32'h000);

    $display("[TB] square period with attenuation, then triangle");
    for (int i = 1; i <= 128; i++) begin
      apply_stimulus();
      if (i == 127) check_output("square_step127", 32'(sample), 32'h000);
    end
    check_output("square_step128", 32'(sample), 32'hFFF);
    amp_shift = 2'd2;
    apply_stimulus();
    check_output("square_shift2", 32'(sample), 32'h3FF);
    amp_shift = 2'd0;
    wave_sel  = WAVE_TRI;
    for (int i = 130; i <= 256; i++) apply_stimulus();
    for (int i = 1; i <= 192; i++) begin
      apply_stimulus();
      if (i == 64) check_output("tri_step64", 32'(sample), 32'h810);
    end
    check_output("tri_step192", 32'(sample), 32'h7EF);

    $display("[TB] enable dropped on the same edge as a step");
    wave_sel = WAVE_SAW;
    enable   = 1'b0;
    model_disable();
    repeat (3) @(negedge clk);
    check_output("disabled_sample", 32'(sample), 32'd0);
    enable = 1'b1;
    for (int i = 1; i <= 100; i++) apply_stimulus();
    check_output("saw_step100", 32'(sample), 32'h646);
    step_in = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    model_disable();
    repeat (8) @(negedge clk);
    step_in = 1'b0;
    repeat (10) @(negedge clk);
    check_output("drop_sample", 32'(sample), 32'd0);
    check_output("drop_sb_drain", 32'(sb.size()), 32'd0);
    apply_stimulus();
    enable = 1'b1;
    apply_stimulus();
    check_output("reenable_phase1", 32'(sample), 32'h010);

    $display("[TB] DC level with attenuation");
    enable   = 1'b0;
    wave_sel = WAVE_DC;
    model_disable();
    repeat (3) @(negedge clk);
    enable = 1'b1;
    apply_stimulus();
    check_output("dc_level", 32'(sample), 32'h800);
    amp_shift = 2'd1;
    apply_stimulus();
    check_output("dc_shift1", 32'(sample), 32'h400);
    amp_shift = 2'd0;

    $display("[TB] reset mid-period with step_in held high");
    step_in = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_reset_sample", 32'(sample), 32'd0);
    check_output("async_reset_valid", 32'(sample_valid), 32'd0);
    enable   = 1'b0;
    wave_sel = WAVE_DC;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    model_disable();
    repeat (20) @(negedge clk);
    check_output("held_high_sample", 32'(sample), 32'd0);
    check_output("held_high_sb_drain", 32'(sb.size()), 32'd0);
    step_in = 1'b0;
    repeat (10) @(negedge clk);
    push_step();
    step_in = 1'b1;
    @(negedge clk);
    check_output("latency_edge_k", 32'(sample_valid), 32'd0);
    @(negedge clk);
    check_output("latency_edge_k1", 32'(sample_valid), 32'd0);
    @(negedge clk);
    check_output("latency_edge_k2", 32'(sample_valid), 32'd1);
    repeat (7) @(negedge clk);
    step_in = 1'b0;
    repeat (10) @(negedge clk);
    check_output("post_reset_dc", 32'(sample), 32'h800);
    check_output("final_sb_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wave_gen.md
WAVE_GEN -- requirements
Module: wave_gen

Interface
REQ-001 SHALL have parameter PHASE_W, default 8, phase accumulator width.
REQ-002 SHALL have parameter SAMPLE_W, default 12, output sample width (SAMPLE_W >= PHASE_W).
REQ-003 SHALL have port clk  input  1  system clock; the only clock; all flops on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port step_in  input  1  divided clock from the clock-divider stage (new_clk); treated as data.
REQ-006 SHALL have port enable  input  1  generator run enable.
REQ-007 SHALL have port wave_sel  input  2  requested waveform: 00 square, 01 sawtooth, 10 triangle, 11 DC midscale.
REQ-008 SHALL have port amp_shift  input  2  attenuation; sample is logically right-shifted by this amount.
REQ-009 SHALL have port sample  output  SAMPLE_W  current waveform sample to DAC stage.
REQ-010 SHALL have port sample_valid  output  1  one-cycle pulse: new sample this cycle.
REQ-011 SHALL have port cycle_start  output  1  one-cycle pulse coincident with sample_valid when phase becomes 0.

Function
REQ-012 step_in SHALL pass a 2-flop synchronizer plus one history flop; step = sync2 & ~hist (rising-edge detect, one clk wide).
REQ-013 First clk edge sampling step_in high = edge k; phase update, sample and sample_valid SHALL register at edge k+2 (latency 3 edges); step_in high/low for fewer than 2 clk cycles may be lost (not required to be detected).
REQ-014 On step with enable=1, phase SHALL increment by 1 modulo 2^PHASE_W (max wraps to 0, no saturation).
REQ-015 Active mode SHALL load from wave_sel only when phase wraps to 0 (same edge) or while enable=0; wave_sel changes mid-period take effect at next wrap.
REQ-016 Sample SHALL be computed from the updated phase p and the mode active after that edge's load.
REQ-017 Square: all-ones if p MSB=1, else 0.
REQ-018 Sawtooth: p replicated MSB-first to fill SAMPLE_W bits (default: {p, p[7:4]}).
REQ-019 Triangle: t = p MSB ? ~p[PHASE_W-2:0] : p[PHASE_W-2:0]; t replicated MSB-first to SAMPLE_W bits.
REQ-020 DC: 1 followed by SAMPLE_W-1 zeros (default 2048).
REQ-021 Raw sample SHALL be logically shifted right by amp_shift (sampled at the same edge) before registering.
REQ-022 sample SHALL hold its value between steps; sample_valid high exactly one cycle per accepted step.
REQ-023 cycle_start SHALL assert with sample_valid only when the updated phase equals 0.
REQ-024 enable=0: phase forced to 0, sample forced to 0, sample_valid and cycle_start 0; steps discarded.
REQ-025 step and enable falling at the same edge: enable wins, no sample_valid.
REQ-026 enable rising: first step after it yields phase 1; synchronizer keeps running while disabled so no spurious step occurs on enable.

Reset
REQ-027 rst_n low SHALL asynchronously clear synchronizer and history flops, phase, sample, sample_valid, cycle_start to 0 and active mode to 00.
REQ-028 Reset release SHALL not generate a step even if step_in is high; first step requires a fresh low-to-high on step_in.
REQ-029 Reset asserted mid-period SHALL abort immediately; no partial-cycle output after release.

Structure
REQ-030 Package wave_gen_pkg SHALL hold waveform mode encodings (WAVE_SQUARE, WAVE_SAW, WAVE_TRI, WAVE_DC) and default PHASE_W/SAMPLE_W constants.
REQ-031 Synchronizer and edge detect SHALL be a sub-module step_sync (clk, rst_n, step_in, step).
REQ-032 Waveform mapping SHALL be combinational; only phase, mode, sample and pulse outputs are registered.

Verification
REQ-033 Reset then enable=1, saw, amp_shift=0, step_in period 20 clk: samples 0x010,0x020,...; after 256 steps phase=0, sample=0x000, cycle_start=1.
REQ-034 Square: step 127 -> sample 0x000, step 128 -> 0xFFF; triangle step 64 -> 0x810, step 192 -> 0x7EF.
REQ-035 Change wave_sel saw->square at phase 50: saw continues to step 255; square starts at wrap (sample 0x000, cycle_start=1).
REQ-036 amp_shift=2 on square high half: sample 0x3FF; DC mode: 0x800, amp_shift=1 gives 0x400.
REQ-037 Hold step_in high across reset release: no sample_valid until step_in toggles low then high; edge at k gives sample_valid after edge k+2.
REQ-038 Drop enable at phase 100 on same edge as step: no sample_valid, sample=0; re-enable and step -> phase 1.
